controlador_ejecao: RTL and testbench

Sequencing controller for the product-ejection mechanism of the vending machine. It accumulates coin credit, validates a product selection against a fixed price table, and drives the `ejeta` line for a fixed number of cycles. It then returns change and handles cancellation and inactivity timeout. It sits between the coin and keypad front end and the ejection actuator, and replaces ad-hoc ejection timing with one explicit FSM.

---
 rtl/controlador_ejecao_pkg.sv | 30 +++
 rtl/controlador_ejecao_temporizador.sv | 36 +++
 rtl/controlador_ejecao.sv | 163 ++++++++++++++++
 tb/tb_controlador_ejecao.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_ejecao_pkg.sv
// Shared definitions for the vending-machine ejection controller:
// FSM state encoding, credit width and the fixed product price table.
package controlador_ejecao_pkg;

    localparam int LARGURA_CREDITO = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CREDITO = 2'd1,
        ST_EJETA   = 2'd2,
        ST_TROCO   = 2'd3
    } estado_t;

    localparam logic [LARGURA_CREDITO-1:0] PRECO_0 = 8'd50;
    localparam logic [LARGURA_CREDITO-1:0] PRECO_1 = 8'd75;
    localparam logic [LARGURA_CREDITO-1:0] PRECO_2 = 8'd100;
    localparam logic [LARGURA_CREDITO-1:0] PRECO_3 = 8'd120;

    function automatic logic [LARGURA_CREDITO-1:0] preco(input logic [1:0] produto);
        logic [LARGURA_CREDITO-1:0] valor;
        case (produto)
            2'd0:    valor = PRECO_0;
            2'd1:    valor = PRECO_1;
            2'd2:    valor = PRECO_2;
            default: valor = PRECO_3;
        endcase
        return valor;
    endfunction

endpackage

// File: rtl/controlador_ejecao_temporizador.sv
// 9-bit inactivity timer: counts while enabled, clear wins over enable,
// flags the terminal count TIMEOUT_CICLOS-1 and holds there.
module temporizador_inatividade #(
    parameter int unsigned TIMEOUT_CICLOS = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic fim_o
);

    localparam logic [8:0] TERMINAL = 9'(TIMEOUT_CICLOS - 1);

    logic [8:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (limpa_i) begin
            cont_d = '0;
        end else if (habilita_i && (cont_q != TERMINAL)) begin
            cont_d = cont_q + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim_o = (cont_q == TERMINAL);

endmodule

// File: rtl/controlador_ejecao.sv
// Ejection sequencer: accumulates coin credit, checks a selection against the
// price table, holds ejeta for EJETA_CICLOS cycles, then returns change.
module controlador_ejecao
    import controlador_ejecao_pkg::*;
#(
    parameter int unsigned EJETA_CICLOS   = 5,
    parameter int unsigned TIMEOUT_CICLOS = 400
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       moeda,
    input  logic [LARGURA_CREDITO-1:0] valor_moeda,
    input  logic                       seleciona,
    input  logic [1:0]                 produto,
    input  logic                       cancela,
    output logic                       ejeta,
    output logic [1:0]                 produto_ejetado,
    output logic [LARGURA_CREDITO-1:0] credito,
    output logic [LARGURA_CREDITO-1:0] troco,
    output logic                       troco_valido,
    output logic                       erro_saldo,
    output logic                       moeda_rejeitada,
    output logic                       ocupado
);

    estado_t                      estado_q, estado_d;
    logic [LARGURA_CREDITO-1:0]   credito_q, credito_d;
    logic [7:0]                   cont_q, cont_d;
    logic [1:0]                   produto_q, produto_d;
    logic [LARGURA_CREDITO-1:0]   troco_q, troco_d;
    logic                         troco_valido_q, troco_valido_d;
    logic                         erro_q, erro_d;
    logic                         rejeita_q, rejeita_d;
    logic                         ejeta_q, ejeta_d;
    logic                         ocupado_q, ocupado_d;

    logic [LARGURA_CREDITO:0]     soma;
    logic                         excede;
    logic [LARGURA_CREDITO-1:0]   credito_moeda;
    logic [LARGURA_CREDITO-1:0]   preco_sel;
    logic                         timer_fim;

    temporizador_inatividade #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk       (clk),
        .rst       (rst),
        .limpa_i   ((estado_q != ST_CREDITO) || moeda || seleciona),
        .habilita_i(estado_q == ST_CREDITO),
        .fim_o     (timer_fim)
    );

    // Coin is accepted only if the 9-bit sum fits; otherwise credit is untouched.
    assign soma          = {1'b0, credito_q} + {1'b0, valor_moeda};
    assign excede        = soma[LARGURA_CREDITO];
    assign credito_moeda = (moeda && !excede) ? soma[LARGURA_CREDITO-1:0] : credito_q;
    assign preco_sel     = preco(produto);

    always_comb begin
        estado_d       = estado_q;
        credito_d      = credito_q;
        cont_d         = cont_q;
        produto_d      = produto_q;
        troco_d        = '0;
        troco_valido_d = 1'b0;
        erro_d         = 1'b0;
        rejeita_d      = 1'b0;

        case (estado_q)
            ST_IDLE: begin
                if (moeda) begin
                    credito_d = valor_moeda;
                    estado_d  = ST_CREDITO;
                end
            end
            ST_CREDITO: begin
                rejeita_d = moeda && excede;
                if (cancela) begin
                    credito_d      = credito_moeda;
                    troco_d        = credito_moeda;
                    troco_valido_d = 1'b1;
                    estado_d       = ST_TROCO;
                end else if (seleciona) begin
                    // Price is checked against the pre-coin credit; a same-cycle
                    // coin then lands on the residual.
                    if (credito_q >= preco_sel) begin
                        credito_d = credito_moeda - preco_sel;
                        produto_d = produto;
                        cont_d    = 8'(EJETA_CICLOS);
                        estado_d  = ST_EJETA;
                    end else begin
                        erro_d    = 1'b1;
                        credito_d = credito_moeda;
                    end
                end else if (timer_fim && !moeda) begin
                    troco_d        = credito_q;
                    troco_valido_d = 1'b1;
                    estado_d       = ST_TROCO;
                end else begin
                    credito_d = credito_moeda;
                end
            end
            ST_EJETA: begin
                rejeita_d = moeda;
                cont_d    = cont_q - 8'd1;
                if (cont_q == 8'd1) begin
                    produto_d = '0;
                    if (credito_q != '0) begin
                        troco_d        = credito_q;
                        troco_valido_d = 1'b1;
                        estado_d       = ST_TROCO;
                    end else begin
                        estado_d = ST_IDLE;
                    end
                end
            end
            default: begin
                rejeita_d = moeda;
                credito_d = '0;
                estado_d  = ST_IDLE;
            end
        endcase

        ejeta_d   = (estado_d == ST_EJETA);
        ocupado_d = (estado_d == ST_EJETA) || (estado_d == ST_TROCO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= ST_IDLE;
            credito_q      <= '0;
            cont_q         <= '0;
            produto_q      <= '0;
            troco_q        <= '0;
            troco_valido_q <= 1'b0;
            erro_q         <= 1'b0;
            rejeita_q      <= 1'b0;
            ejeta_q        <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            credito_q      <= credito_d;
            cont_q         <= cont_d;
            produto_q      <= produto_d;
            troco_q        <= troco_d;
            troco_valido_q <= troco_valido_d;
            erro_q         <= erro_d;
            rejeita_q      <= rejeita_d;
            ejeta_q        <= ejeta_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign ejeta           = ejeta_q;
    assign produto_ejetado = produto_q;
    assign credito         = credito_q;
    assign troco           = troco_q;
    assign troco_valido    = troco_valido_q;
    assign erro_saldo      = erro_q;
    assign moeda_rejeitada = rejeita_q;
    assign ocupado         = ocupado_q;

endmodule

// File: tb/tb_controlador_ejecao.sv
// Scenario bench for controlador_ejecao: directed cases plus randomized
// purchase sessions checked against a transaction-level credit model.
module tb_controlador_ejecao;

    logic       clk = 1'b0;
    logic       rst;
    logic       moeda;
    logic [7:0] valor_moeda;
    logic       seleciona;
    logic [1:0] produto;
    logic       cancela;
    logic       ejeta;
    logic [1:0] produto_ejetado;
    logic [7:0] credito;
    logic [7:0] troco;
    logic       troco_valido;
    logic       erro_saldo;
    logic       moeda_rejeitada;
    logic       ocupado;

    int n_chk  = 0;
    int n_fail = 0;
    int precos[4] = '{50, 75, 100, 120};
    localparam int EJ  = 5;
    localparam int TMO = 400;

    controlador_ejecao dut (
        .clk            (clk),
        .rst            (rst),
        .moeda          (moeda),
        .valor_moeda    (valor_moeda),
        .seleciona      (seleciona),
        .produto        (produto),
        .cancela        (cancela),
        .ejeta          (ejeta),
        .produto_ejetado(produto_ejetado),
        .credito        (credito),
        .troco          (troco),
        .troco_valido   (troco_valido),
        .erro_saldo     (erro_saldo),
        .moeda_rejeitada(moeda_rejeitada),
        .ocupado        (ocupado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poe_moeda(input int v);
        moeda = 1'b1; valor_moeda = 8'(v);
        step();
        moeda = 1'b0;
    endtask

    task automatic escolhe(input int p);
        seleciona = 1'b1; produto = 2'(p);
        step();
        seleciona = 1'b0;
    endtask

    task automatic cancelar();
        cancela = 1'b1;
        step();
        cancela = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (ejeta !== 1'b0) begin n_fail++; $display("FAIL reset_ejeta: got %0b expected 0", ejeta); end
        n_chk++; if (credito !== 8'd0) begin n_fail++; $display("FAIL reset_credito: got %0d expected 0", credito); end
        n_chk++; if (troco_valido !== 1'b0 || troco !== 8'd0) begin n_fail++; $display("FAIL reset_troco: got %0b/%0d expected 0/0", troco_valido, troco); end
        n_chk++; if (ocupado !== 1'b0 || erro_saldo !== 1'b0 || moeda_rejeitada !== 1'b0 || produto_ejetado !== 2'd0) begin
            n_fail++; $display("FAIL reset_flags: got oc=%0b es=%0b mr=%0b pe=%0d expected all 0", ocupado, erro_saldo, moeda_rejeitada, produto_ejetado); end
        escolhe(3);
        n_chk++; if (erro_saldo !== 1'b0 || ejeta !== 1'b0) begin n_fail++; $display("FAIL idle_seleciona: got es=%0b ej=%0b expected 0/0", erro_saldo, ejeta); end
        cancelar();
        n_chk++; if (troco_valido !== 1'b0) begin n_fail++; $display("FAIL idle_cancela: got %0b expected 0", troco_valido); end
    endtask

    task automatic test_compra_troco();
        int n;
        poe_moeda(100);
        n_chk++; if (credito !== 8'd100) begin n_fail++; $display("FAIL compra_credito: got %0d expected 100", credito); end
        escolhe(1);
        n_chk++; if (ejeta !== 1'b1 || produto_ejetado !== 2'd1 || credito !== 8'd25 || ocupado !== 1'b1) begin
            n_fail++; $display("FAIL compra_inicio: got ej=%0b pe=%0d cr=%0d oc=%0b expected 1/1/25/1", ejeta, produto_ejetado, credito, ocupado); end
        n = 1;
        for (int i = 0; i < 20; i++) begin step(); if (!ejeta) break; n++; end
        n_chk++; if (n != EJ) begin n_fail++; $display("FAIL compra_duracao: got %0d expected %0d", n, EJ); end
        n_chk++; if (troco_valido !== 1'b1 || troco !== 8'd25) begin n_fail++; $display("FAIL compra_troco: got %0b/%0d expected 1/25", troco_valido, troco); end
        step();
        n_chk++; if (troco_valido !== 1'b0 || credito !== 8'd0 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL compra_fim: got tv=%0b cr=%0d oc=%0b expected 0/0/0", troco_valido, credito, ocupado); end
    endtask

    task automatic test_saldo_insuficiente();
        int n;
        poe_moeda(50);
        escolhe(3);
        n_chk++; if (erro_saldo !== 1'b1 || ejeta !== 1'b0 || credito !== 8'd50) begin
            n_fail++; $display("FAIL saldo_erro: got es=%0b ej=%0b cr=%0d expected 1/0/50", erro_saldo, ejeta, credito); end
        step();
        n_chk++; if (erro_saldo !== 1'b0) begin n_fail++; $display("FAIL saldo_pulso: got %0b expected 0", erro_saldo); end
        poe_moeda(100);
        n_chk++; if (credito !== 8'd150) begin n_fail++; $display("FAIL saldo_soma: got %0d expected 150", credito); end
        escolhe(3);
        n = 0;
        for (int i = 0; i < 20; i++) begin if (!ejeta) break; n++; step(); end
        n_chk++; if (n != EJ) begin n_fail++; $display("FAIL saldo_duracao: got %0d expected %0d", n, EJ); end
        n_chk++; if (troco_valido !== 1'b1 || troco !== 8'd30) begin n_fail++; $display("FAIL saldo_troco: got %0b/%0d expected 1/30", troco_valido, troco); end
        step();
    endtask

    task automatic test_overflow();
        poe_moeda(200);
        poe_moeda(100);
        n_chk++; if (moeda_rejeitada !== 1'b1 || credito !== 8'd200) begin
            n_fail++; $display("FAIL overflow: got mr=%0b cr=%0d expected 1/200", moeda_rejeitada, credito); end
        poe_moeda(55);
        n_chk++; if (moeda_rejeitada !== 1'b0 || credito !== 8'd255) begin
            n_fail++; $display("FAIL overflow_limite: got mr=%0b cr=%0d expected 0/255", moeda_rejeitada, credito); end
        cancelar();
        n_chk++; if (troco_valido !== 1'b1 || troco !== 8'd255) begin n_fail++; $display("FAIL overflow_troco: got %0b/%0d expected 1/255", troco_valido, troco); end
        step();
    endtask

    task automatic test_timeout();
        int n;
        poe_moeda(40);
        n = 0;
        for (int i = 0; i < 1000; i++) begin step(); n++; if (troco_valido) break; end
        n_chk++; if (n != TMO || troco !== 8'd40) begin n_fail++; $display("FAIL timeout: got %0d cycles troco %0d expected %0d cycles troco 40", n, troco, TMO); end
        step();
        poe_moeda(40);
        n = 0;
        for (int i = 0; i < TMO - 2; i++) begin step(); if (troco_valido) n++; end
        poe_moeda(10);
        n_chk++; if (n != 0 || troco_valido !== 1'b0) begin n_fail++; $display("FAIL timeout_cedo: got %0d strobes expected 0", n); end
        n = 0;
        for (int i = 0; i < 1000; i++) begin step(); n++; if (troco_valido) break; end
        n_chk++; if (n != TMO || troco !== 8'd50) begin n_fail++; $display("FAIL timeout_reinicio: got %0d cycles troco %0d expected %0d cycles troco 50", n, troco, TMO); end
        step();
    endtask

    task automatic test_moeda_com_selecao();
        poe_moeda(75);
        seleciona = 1'b1; produto = 2'd0; moeda = 1'b1; valor_moeda = 8'd20;
        step();
        seleciona = 1'b0; moeda = 1'b0;
        n_chk++; if (ejeta !== 1'b1 || produto_ejetado !== 2'd0 || credito !== 8'd45) begin
            n_fail++; $display("FAIL simultaneo: got ej=%0b pe=%0d cr=%0d expected 1/0/45", ejeta, produto_ejetado, credito); end
        step();
        poe_moeda(10);
        n_chk++; if (moeda_rejeitada !== 1'b1 || credito !== 8'd45 || ejeta !== 1'b1) begin
            n_fail++; $display("FAIL moeda_em_ejecao: got mr=%0b cr=%0d ej=%0b expected 1/45/1", moeda_rejeitada, credito, ejeta); end
        for (int i = 0; i < 20; i++) begin if (!ejeta) break; step(); end
        n_chk++; if (troco_valido !== 1'b1 || troco !== 8'd45) begin n_fail++; $display("FAIL simultaneo_troco: got %0b/%0d expected 1/45", troco_valido, troco); end
        step();
    endtask

    task automatic test_reset_em_ejecao();
        int strobes;
        poe_moeda(100);
        escolhe(0);
        step();
        step();
        n_chk++; if (ejeta !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %0b expected 1", ejeta); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (ejeta !== 1'b0 || credito !== 8'd0 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got ej=%0b cr=%0d oc=%0b expected 0/0/0", ejeta, credito, ocupado); end
        step();
        step();
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin step(); if (troco_valido || ejeta) strobes++; end
        n_chk++; if (strobes != 0) begin n_fail++; $display("FAIL rst_sem_troco: got %0d active cycles expected 0", strobes); end
        poe_moeda(30);
        n_chk++; if (credito !== 8'd30 || moeda_rejeitada !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle: got cr=%0d mr=%0b expected 30/0", credito, moeda_rejeitada); end
        cancelar();
        step();
    endtask

    task automatic test_aleatorio();
        int m_credit, v, p, n, resto, acao;
        bit exp_rej;
        for (int s = 0; s < 30; s++) begin
            m_credit = 0;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                v = int'($urandom_range(1, 200));
                exp_rej = (k > 0) && (m_credit + v > 255);
                if (!exp_rej) m_credit = m_credit + v;
                poe_moeda(v);
                n_chk++; if (moeda_rejeitada !== exp_rej || credito !== 8'(m_credit)) begin
                    n_fail++; $display("FAIL rnd_moeda s%0d: got mr=%0b cr=%0d expected %0b/%0d", s, moeda_rejeitada, credito, exp_rej, m_credit); end
            end
            acao = int'($urandom_range(0, 2));
            p = int'($urandom_range(0, 3));
            if (acao != 2 && m_credit >= precos[p]) begin
                resto = m_credit - precos[p];
                escolhe(p);
                n_chk++; if (ejeta !== 1'b1 || produto_ejetado !== 2'(p) || credito !== 8'(resto)) begin
                    n_fail++; $display("FAIL rnd_ejeta s%0d: got ej=%0b pe=%0d cr=%0d expected 1/%0d/%0d", s, ejeta, produto_ejetado, credito, p, resto); end
                n = 0;
                for (int i = 0; i < 20; i++) begin if (!ejeta) break; n++; step(); end
                n_chk++; if (n != EJ || troco_valido !== (resto > 0) || (resto > 0 && troco !== 8'(resto))) begin
                    n_fail++; $display("FAIL rnd_fim s%0d: got n=%0d tv=%0b tr=%0d expected n=%0d troco %0d", s, n, troco_valido, troco, EJ, resto); end
                if (resto > 0) step();
            end else begin
                if (acao != 2) begin
                    escolhe(p);
                    n_chk++; if (erro_saldo !== 1'b1 || ejeta !== 1'b0 || credito !== 8'(m_credit)) begin
                        n_fail++; $display("FAIL rnd_erro s%0d: got es=%0b ej=%0b cr=%0d expected 1/0/%0d", s, erro_saldo, ejeta, credito, m_credit); end
                end
                cancelar();
                n_chk++; if (troco_valido !== 1'b1 || troco !== 8'(m_credit)) begin
                    n_fail++; $display("FAIL rnd_cancela s%0d: got %0b/%0d expected 1/%0d", s, troco_valido, troco, m_credit); end
                step();
            end
            n_chk++; if (credito !== 8'd0 || ocupado !== 1'b0) begin
                n_fail++; $display("FAIL rnd_idle s%0d: got cr=%0d oc=%0b expected 0/0", s, credito, ocupado); end
        end
    endtask

    initial begin
        rst = 1'b1; moeda = 1'b0; valor_moeda = 8'd0;
        seleciona = 1'b0; produto = 2'd0; cancela = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_compra_troco();
        test_saldo_insuficiente();
        test_overflow();
        test_timeout();
        test_moeda_com_selecao();
        test_reset_em_ejecao();
        test_aleatorio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
